// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, flag bit positions
// and controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_SUM  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MULT = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9
    } alu_op_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } alu_state_e;

endpackage

// File: rtl/alu_seq_divider.sv
// Iterative restoring unsigned divider. quotient/remainder present the result
// of the step being taken this cycle, so they are final while done is high.
module divider_iter #(
    parameter int N                  = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);
    localparam int ITERS = N / DIV_BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    logic [N-1:0]  rem_q, quo_q, dsr_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  rem_d, quo_d;
    logic [N:0]    trial;

    // Dividend bits shift out of quo_q's top while quotient bits enter at bit 0.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        trial = '0;
        for (int j = 0; j < DIV_BITS_PER_CYCLE; j++) begin
            trial = {rem_d, quo_d[N-1]};
            quo_d = {quo_d[N-2:0], 1'b0};
            if (trial >= {1'b0, dsr_q}) begin
                trial    = trial - {1'b0, dsr_q};
                quo_d[0] = 1'b1;
            end
            rem_d = trial[N-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CW'(ITERS);
        end else if (cnt_q != '0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign quotient  = quo_d;
    assign remainder = rem_d;
    assign done      = (cnt_q == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides. Single-cycle ops are
// resolved at acceptance; div/mod with a nonzero divisor iterate in divider_iter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N                  = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   func,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic [3:0]   flags
);
    alu_state_e   state_q, state_d;
    alu_op_e      op_q;
    logic [N-1:0] y_q;
    logic [3:0]   flags_q;

    logic           accept, div_start, div_done, is_div;
    logic [N-1:0]   quo, rem, res_c, div_res;
    logic [N:0]     sum_w, sub_w;
    logic [2*N-1:0] prod_w;
    logic           v_c, c_c, dz_c;
    logic [3:0]     flg_c;

    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign sub_w  = {1'b0, A} - {1'b0, B};
    assign prod_w = {{N{1'b0}}, A} * {{N{1'b0}}, B};
    assign is_div = (func == OP_DIV) || (func == OP_MOD);

    always_comb begin
        res_c = '0;
        v_c   = 1'b0;
        c_c   = 1'b0;
        dz_c  = 1'b0;
        case (alu_op_e'(func))
            OP_SUM: begin
                res_c = sum_w[N-1:0];
                c_c   = sum_w[N];
                v_c   = (A[N-1] == B[N-1]) && (sum_w[N-1] != A[N-1]);
            end
            OP_SUB: begin
                res_c = sub_w[N-1:0];
                c_c   = ~sub_w[N];
                v_c   = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
            end
            OP_MULT: begin
                res_c = prod_w[N-1:0];
                v_c   = |prod_w[2*N-1:N];
            end
            // Only reach the result register when B is zero.
            OP_DIV: begin res_c = '1; dz_c = 1'b1; end
            OP_MOD: begin res_c = A;  dz_c = 1'b1; end
            OP_AND: res_c = A & B;
            OP_OR:  res_c = A | B;
            OP_XOR: res_c = A ^ B;
            OP_SHL: res_c = (B < N'(N)) ? (A << B) : '0;
            OP_SHR: res_c = (B < N'(N)) ? (A >> B) : '0;
            default: res_c = '0;
        endcase
    end

    always_comb begin
        flg_c = '0;
        if (dz_c) begin
            flg_c[FLAG_V] = 1'b1;
        end else begin
            flg_c[FLAG_V] = v_c;
            flg_c[FLAG_C] = c_c;
            flg_c[FLAG_Z] = (res_c == '0);
            flg_c[FLAG_N] = res_c[N-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (is_div && (B != '0)) begin
                        div_start = 1'b1;
                        state_d   = CALC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CALC: if (div_done) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign div_res = (op_q == OP_DIV) ? quo : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_SUM;
            y_q     <= '0;
            flags_q <= '0;
        end else if (accept) begin
            op_q <= alu_op_e'(func);
            if (!div_start) begin
                y_q     <= res_c;
                flags_q <= flg_c;
            end
        end else if (state_q == CALC && div_done) begin
            y_q     <= div_res;
            flags_q <= {div_res[N-1], (div_res == '0), 2'b00};
        end
    end

    divider_iter #(.N(N), .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_start),
        .dividend  (A),
        .divisor   (B),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=32) with a transaction-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_alu_seq;
    localparam int N = 32;

    logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] A, B, Y;
    logic [3:0]   func, flags;

    int total = 0;
    int bad   = 0;

    alu_seq #(.N(N), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .func(func), .out_valid(out_valid),
        .out_ready(out_ready), .Y(Y), .flags(flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: returns {flags, Y} from plain arithmetic.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
        logic [31:0] y;
        logic [63:0] w;
        longint      s;
        logic        v, c, dz;
        y = 0; v = 0; c = 0; dz = 0; w = 0; s = 0;
        case (f)
            4'd0: begin
                w = {32'b0, a} + {32'b0, b}; y = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                y = a - b; c = (a >= b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: begin w = {32'b0, a} * {32'b0, b}; y = w[31:0]; v = (w[63:32] != 0); end
            4'd3: if (b == 0) begin y = 32'hFFFF_FFFF; dz = 1; end else y = a / b;
            4'd4: if (b == 0) begin y = a; dz = 1; end else y = a % b;
            4'd5: y = a & b;
            4'd6: y = a | b;
            4'd7: y = a ^ b;
            4'd8: y = (b >= 32) ? 32'd0 : a << b;
            4'd9: y = (b >= 32) ? 32'd0 : a >> b;
            default: y = 0;
        endcase
        if (dz) return {4'b0001, y};
        return {y[31], (y == 0), c, v, y};
    endfunction

    bit          m_started = 0, m_busy = 0, m_valid = 0;
    int          m_wait = 0;
    logic [35:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_started <= 1; m_busy <= 0; m_valid <= 0; m_wait <= 0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid <= 0; m_busy <= 0; end
        end else if (m_busy) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1;
        end else if (in_valid) begin
            m_busy <= 1;
            m_res  <= model(A, B, func);
            if ((func == 4'd3 || func == 4'd4) && B != 0) m_wait <= N;
            else m_valid <= 1;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("model_in_ready", 64'(in_ready), 64'(!m_busy));
            chk("model_out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("model_y", 64'(Y), 64'(m_res[31:0]));
                chk("model_flags", 64'(flags), 64'(m_res[35:32]));
            end
        end
    end

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, input logic [31:0] ey, input logic [3:0] ef,
                          output int lat);
        @(negedge clk);
        A = a; B = b; func = f; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_y"}, 64'(Y), 64'(ey));
        chk({name, "_flags"}, 64'(flags), 64'(ef));
    endtask

    initial begin
        int lat;
        rst = 1; in_valid = 0; out_ready = 1; A = 0; B = 0; func = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_y", 64'(Y), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));

        run_op("sum_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 4'b1001, lat);
        chk("sum_lat", 64'(lat), 64'(0));
        run_op("sum_carry", 32'hFFFF_FFFF, 32'd1, 4'd0, 32'h0, 4'b0110, lat);
        run_op("div", 32'd100, 32'd7, 4'd3, 32'd14, 4'b0000, lat);
        chk("div_lat", 64'(lat), 64'(32));
        run_op("mod", 32'd100, 32'd7, 4'd4, 32'd2, 4'b0000, lat);
        chk("mod_lat", 64'(lat), 64'(32));
        run_op("div0", 32'd5, 32'd0, 4'd3, 32'hFFFF_FFFF, 4'b0001, lat);
        chk("div0_lat", 64'(lat), 64'(0));
        run_op("mod0", 32'd5, 32'd0, 4'd4, 32'd5, 4'b0001, lat);
        run_op("sub_borrow", 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 4'b1000, lat);
        run_op("sub_nob", 32'd7, 32'd5, 4'd1, 32'd2, 4'b0010, lat);
        run_op("sub_ovf", 32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 4'b0011, lat);
        run_op("shl31", 32'd1, 32'd31, 4'd8, 32'h8000_0000, 4'b1000, lat);
        run_op("shl32", 32'd1, 32'd32, 4'd8, 32'h0, 4'b0100, lat);
        run_op("shr4", 32'h8000_0000, 32'd4, 4'd9, 32'h0800_0000, 4'b0000, lat);
        run_op("xor_self", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd7, 32'h0, 4'b0100, lat);
        run_op("and", 32'hF0F0_1234, 32'h0FF0_FF00, 4'd5, 32'h00F0_1200, 4'b0000, lat);
        run_op("or", 32'h8000_0000, 32'h0000_0001, 4'd6, 32'h8000_0001, 4'b1000, lat);
        run_op("reserved", 32'd3, 32'd4, 4'd12, 32'h0, 4'b0100, lat);
        run_op("div_big", 32'hFFFF_FFFF, 32'd3, 4'd3, 32'h5555_5555, 4'b0000, lat);

        // Backpressure: result held while out_ready is low, new requests ignored.
        @(negedge clk);
        out_ready = 0;
        A = 32'h1_0000; B = 32'h1_0000; func = 4'd2; in_valid = 1;
        @(negedge clk);
        A = 32'd1; B = 32'd2; func = 4'd0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_y", 64'(Y), 64'(0));
            chk("bp_flags", 64'(flags), 64'(4'b0101));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        chk("bp_release_idle", 64'(in_ready), 64'(1));
        chk("bp_release_valid", 64'(out_valid), 64'(0));

        // Reset in the middle of a division.
        A = 32'd100; B = 32'd7; func = 4'd3; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 64'(in_ready), 64'(0));
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_y", 64'(Y), 64'(0));
        run_op("after_rst", 32'd3, 32'd4, 4'd0, 32'd7, 4'b0000, lat);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle, parametrised successor to the combinational processor ALU. Keeps the same func encoding and flag layout.
- Adds a valid/ready handshake on both sides, registered outputs, and an iterative unsigned divider that produces quotient (div) and remainder (mod).
- Adds zero/negative flag generation for every operation.
- Sits between the decode/operand-fetch stage and writeback; the pipeline stalls on in_ready/out_valid.

Parameters:
- N, 32, operand/result width in bits; N >= 4, power of two.
- DIV_BITS_PER_CYCLE, 1, quotient bits resolved per divider iteration; legal values 1, 2; N divisible by it.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/func presented
- in_ready  out  1  block accepts a new operation
- A  in  N  operand A
- B  in  N  operand B (shift amount for shifts)
- func  in  4  0 sum, 1 sub, 2 mult, 3 div, 4 mod, 5 and, 6 or, 7 xor, 8 shl, 9 shr, 10-15 reserved
- out_valid  out  1  Y/flags valid
- out_ready  in  1  consumer accepts result
- Y  out  N  result
- flags  out  4  bit0 overflow, bit1 carry, bit2 zero, bit3 negative

Behaviour:
- Reset (rst=1 at clk edge, from any state, including mid-division):
  - State goes to IDLE.
  - out_valid=0, Y=0, flags=0, iteration counter=0, latched operands=0.
  - in_ready is combinational (state==IDLE) and therefore equals 1 from the first cycle after reset.
- State IDLE: in_ready=1. Transfer occurs when in_valid && in_ready; A, B and func are latched.
  - func in {0,1,2,5,6,7,8,9} or reserved: result computed from the latched values. Next state DONE. Latency 1 cycle (out_valid high the cycle after acceptance).
  - func in {3,4} with B==0: next state DONE. Div: Y = all ones, flags = 0001. Mod: Y = A, flags = 0001. Zero/negative are not evaluated for divide-by-zero.
  - func in {3,4} with B!=0: next state CALC, counter = N/DIV_BITS_PER_CYCLE.
- State CALC: in_ready=0.
  - Restoring unsigned division, DIV_BITS_PER_CYCLE quotient bits per cycle; counter decrements each cycle.
  - When counter reaches 1, Y is loaded with the quotient (div) or remainder (mod), and next state is DONE.
  - Total latency with DIV_BITS_PER_CYCLE=1 is N+1 cycles from acceptance to out_valid.
- State DONE: out_valid=1, in_ready=0. Y/flags held stable until out_ready=1, then next state is IDLE.
  - No accept in the same cycle as result handoff: back-to-back throughput is one op per 2 cycles minimum.
- in_valid while not in IDLE is ignored; the upstream stage holds its operands.
- Arithmetic rules:
  - sum: Y = A+B mod 2^N. carry = carry-out. overflow = signed overflow.
  - sub: Y = A-B mod 2^N. carry = 1 iff A >= B unsigned (no borrow). overflow = signed overflow.
  - mult: Y = low N bits of the unsigned product. overflow = 1 iff the upper N bits are nonzero. carry = 0.
  - shl/shr (logical): shift amount = B as unsigned; if B >= N, Y = 0.
  - and/or/xor/shl/shr/div/mod: overflow = carry = 0.
  - Reserved func: Y = 0.
  - All ops except divide-by-zero: zero = (Y==0), negative = Y[N-1].

Decomposition:
- Package alu_pkg holds:
  - the alu_op_e enum (4-bit codes above);
  - flag bit index constants FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3;
  - the alu_state_e enum (IDLE, CALC, DONE).
- Sub-module divider_iter (parameters N, DIV_BITS_PER_CYCLE):
  - inputs clk, rst, load, dividend, divisor;
  - outputs quotient, remainder, done;
  - holds the partial-remainder/quotient shift registers and the counter.
- Single-cycle ops stay inline as combinational logic feeding the result register.

Test Plan (N=32):
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, Y=0, flags=0.
- sum A=0x7FFFFFFF, B=1 -> one cycle later out_valid=1, Y=0x80000000, flags=1001. Then sum A=0xFFFFFFFF, B=1 -> Y=0, flags=0110.
- div A=100, B=7 -> in_ready low for 32 cycles, out_valid at cycle 33, Y=14, flags=0000. mod with the same operands -> Y=2, flags=0000.
- div A=5, B=0 -> next cycle Y=0xFFFFFFFF, flags=0001. mod A=5, B=0 -> Y=5, flags=0001.
- Backpressure: mult A=0x10000, B=0x10000, out_ready=0 for 5 cycles -> Y=0, flags=0101 held stable, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-division: rst asserted at cycle 10 of div -> next cycle IDLE, out_valid=0, Y=0. A new sum 3+4 then gives Y=7.
